// File: rtl/ram_access_arb.sv
// ============================================================================
// Module   : ram_access_arb
// Brief    : Round-robin write/read arbiter with bounded bursts and an array
//            fill engine, driving a single-port synchronous RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_access_arb #(
    parameter int          AW        = 8,
    parameter int          DW        = 8,
    parameter int          BURST_MAX = 4,
    parameter int          INIT_INC  = 1,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_gnt,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_gnt,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          init_start,
    output logic          init_done,
    output logic          busy,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam int            c_CW   = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [c_CW-1:0] c_BURST_LAST = c_CW'(BURST_MAX - 1);
    localparam logic [AW:0]   c_INIT_LAST = {1'b0, {AW{1'b1}}};

    typedef enum logic [1:0] {
        ST_OWN_W = 2'd0,
        ST_OWN_R = 2'd1,
        ST_INIT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [c_CW-1:0] burst_q, burst_d;
    logic [AW:0]     init_cnt_q, init_cnt_d;
    logic            en_q, en_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   din_q, din_d;
    logic            rd_issue_q, rd_issue_d;
    logic            rd_valid_q;
    logic            init_done_q, init_done_d;

    logic w_own_r;
    logic w_wr_gnt;
    logic w_rd_gnt;

    assign w_own_r = (state_q == ST_OWN_R);

    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        init_cnt_d  = init_cnt_q;
        en_d        = 1'b0;
        we_d        = 1'b0;
        addr_d      = addr_q;
        din_d       = din_q;
        rd_issue_d  = 1'b0;
        init_done_d = 1'b0;
        w_wr_gnt    = 1'b0;
        w_rd_gnt    = 1'b0;

        case (state_q)
            ST_OWN_W, ST_OWN_R: begin
                w_wr_gnt = wr_req && (!rd_req || !w_own_r);
                w_rd_gnt = rd_req && !w_wr_gnt;
                if (w_wr_gnt) begin
                    en_d   = 1'b1;
                    we_d   = 1'b1;
                    addr_d = wr_addr;
                    din_d  = wr_data;
                end else if (w_rd_gnt) begin
                    en_d       = 1'b1;
                    addr_d     = rd_addr;
                    rd_issue_d = 1'b1;
                end
                // Under contention the owner is the one transferring.
                if (wr_req && rd_req) begin
                    if (burst_q == c_BURST_LAST) begin
                        state_d = w_own_r ? ST_OWN_W : ST_OWN_R;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q + c_CW'(1);
                    end
                end else begin
                    burst_d = '0;
                    if (w_wr_gnt) begin
                        state_d = ST_OWN_W;
                    end else if (w_rd_gnt) begin
                        state_d = ST_OWN_R;
                    end
                end
                if (init_start) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                end
            end
            ST_INIT: begin
                en_d       = 1'b1;
                we_d       = 1'b1;
                addr_d     = init_cnt_q[AW-1:0];
                din_d      = (INIT_INC != 0) ? DW'(init_cnt_q[AW-1:0]) : INIT_VAL;
                init_cnt_d = init_cnt_q + (AW+1)'(1);
                if (init_cnt_q == c_INIT_LAST) begin
                    state_d     = ST_OWN_W;
                    burst_d     = '0;
                    init_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_OWN_W;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_OWN_W;
            burst_q     <= '0;
            init_cnt_q  <= '0;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            rd_issue_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            init_cnt_q  <= init_cnt_d;
            en_q        <= en_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rd_issue_q  <= rd_issue_d;
            rd_valid_q  <= rd_issue_q;
            init_done_q <= init_done_d;
        end
    end

    assign wr_gnt    = w_wr_gnt & ~rst;
    assign rd_gnt    = w_rd_gnt & ~rst;
    assign busy      = (state_q == ST_INIT);
    assign ram_en    = en_q;
    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_din   = din_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = ram_dout;
    assign init_done = init_done_q;

endmodule

`default_nettype wire

// File: doc/ram_access_arb.md
Name: ram_access_arb

Overview:
Arbiter and sequencer for the shared single-port 256x8 synchronous RAM. It multiplexes one write requester and one read requester onto the RAM using valid/grant handshakes. Arbitration is round-robin with a bounded burst. A built-in init engine fills the whole array on command. It sits between the key-driven control logic and the RAM primitive and replaces the direct w_en/addr drive of the RAM.

Parameters:
AW, 8, address width; depth = 2^AW
DW, 8, data width
BURST_MAX, 4, maximum consecutive transfers by the priority owner while the other side waits
INIT_INC, 1, fill pattern select: 1 = data is addr[DW-1:0], 0 = INIT_VAL
INIT_VAL, 0, constant fill value when INIT_INC = 0

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
wr_req  in  1  write request; wr_addr and wr_data are valid while high
wr_addr  in  AW  write address
wr_data  in  DW  write data
wr_gnt  out  1  write grant, combinational; transfer occurs on an edge where wr_req and wr_gnt are both high
rd_req  in  1  read request
rd_addr  in  AW  read address
rd_gnt  out  1  read grant, combinational; same transfer rule as wr_gnt
rd_valid  out  1  read data valid, registered
rd_data  out  DW  read data, equal to ram_dout
init_start  in  1  single-cycle pulse that starts the array fill
init_done  out  1  single-cycle pulse after the last fill write is issued
busy  out  1  high while in ST_INIT
ram_en  out  1  RAM enable, registered
ram_we  out  1  RAM write enable, registered
ram_addr  out  AW  RAM address, registered
ram_din  out  DW  RAM write data, registered
ram_dout  in  DW  RAM read data, valid the cycle after a read is issued

Behaviour:
- Reset:
  - All registered outputs are 0.
  - State is ST_OWN_W; burst counter, init counter and read pipeline are cleared.
  - A read in flight at reset produces no rd_valid.
- State machine:
  - ST_OWN_W: write side holds priority.
  - ST_OWN_R: read side holds priority.
  - ST_INIT: array fill in progress.
- Grant logic (ST_OWN_*):
  - At most one grant per cycle.
  - If only one side requests, that side is granted.
  - If both request, the owner is granted.
  - Grants are 0 whenever rst=1 or the state is ST_INIT.
- Burst counter:
  - Increments on each owner transfer made while the other side's req is high.
  - On the transfer that brings the count to BURST_MAX, the state switches to the other owner and the count clears.
  - Clears when the non-owner's req is low.
- Idle hand-off: when only the non-owner transfers, ownership moves to that side and the count clears.
- Transfer pipeline:
  - Transfer at edge E0 sets ram_en=1 and ram_we=1 (write) or 0 (read), with the registered addr/din, during cycle C1.
  - With no transfer, ram_en=0, ram_we=0; addr and din hold.
  - Read: rd_valid=1 during C2 (transfer edge + 2 cycles); rd_data = ram_dout.
  - Throughput is 1 transfer per cycle. A requester may hold req high and change addr/data after each accepted edge.
- Write-then-read ordering: a read of address A issued the cycle after a write to A returns the new data.
- Init sequence:
  - init_start sampled in ST_OWN_* enters ST_INIT at the next edge, but only after the current cycle's transfer, if any, is taken.
  - ST_INIT issues writes to addresses 0 through 2^AW-1 on consecutive cycles, with data per INIT_INC.
  - After the write to address 2^AW-1 is issued, init_done pulses 1 cycle and the state returns to ST_OWN_W with the burst count cleared.
- Init boundaries:
  - init_start during ST_INIT is ignored.
  - The init address counter is AW+1 bits so the terminal compare does not wrap.
  - A read issued the cycle before ST_INIT entry still completes with rd_valid.
- Address and data wrap-around are inherent to the AW/DW widths; no saturation is applied.

Test Plan:
1. Reset then single write: wr_req with addr 0x10, data 0xA5 for 1 cycle -> wr_gnt=1 same cycle; next cycle ram_en=1, ram_we=1, ram_addr=0x10, ram_din=0xA5.
2. Write 0x10=0xA5, then read 0x10 on the next cycle -> rd_valid high 2 cycles after the read transfer edge; rd_data=0xA5.
3. Both req held high continuously, BURST_MAX=4 -> grant pattern W W W W R R R R W; no cycle with both grants; no idle gap.
4. Only rd_req high for 10 cycles in ST_OWN_W -> 10 consecutive read transfers; owner becomes R; rd_valid stream of 10 pulses, each lagging its transfer by 2 cycles.
5. init_start with INIT_INC=1 -> busy for 256 cycles; grants 0; writes to addresses 0..255 with data = address; init_done pulse after address 255; readback of address 0x7F = 0x7F.
6. Assert rst mid-burst and mid-read, and separately during ST_INIT -> outputs go to 0 asynchronously; no rd_valid or init_done afterward; after release, the first transfer is granted to the write side under contention.
